// File: rtl/fetch_unit.sv
// fetch_unit -- decoupled instruction-fetch stage.
//
// Keeps its own fetch PC, issues word-addressed reads to a synchronous
// instruction memory (1-cycle read latency), buffers each returned
// instruction together with its PC in a small prefetch FIFO, and presents
// the FIFO head downstream over a valid/ready handshake. A redirect
// (taken branch/jump) flushes the FIFO and kills any read in flight, then
// restarts fetch at the target.
//
// Ports:
//   CLK              clock, all state updates on the rising edge
//   RST              synchronous active-high reset, overrides all inputs
//   fetch_en         permits issuing new memory requests
//   redirect         taken branch or jump this cycle
//   redirect_target  new fetch PC when redirect=1
//   im_req           memory read request this cycle
//   im_addr          read address (low ADDR_W bits of the fetch PC)
//   im_rdata         read data, valid one cycle after im_req
//   inst_valid       FIFO head holds a valid instruction
//   inst_ready       downstream accepts the head this cycle
//   inst_out         instruction at the FIFO head (0 when empty)
//   inst_pc          PC of inst_out (0 when empty)
//   occupancy        current FIFO entry count

module fetch_unit #(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        ADDR_W   = 10,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    fetch_en,
  input  logic                    redirect,
  input  logic [DATA_W-1:0]       redirect_target,
  output logic                    im_req,
  output logic [ADDR_W-1:0]       im_addr,
  input  logic [DATA_W-1:0]       im_rdata,
  output logic                    inst_valid,
  input  logic                    inst_ready,
  output logic [DATA_W-1:0]       inst_out,
  output logic [DATA_W-1:0]       inst_pc,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [DATA_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     occ_q, occ_d;

  logic [DATA_W-1:0] data_mem_q [DEPTH];
  logic [DATA_W-1:0] pc_mem_q   [DEPTH];

  logic issue_ok_s;
  logic empty_s;
  logic push_s;
  logic pop_s;

  // Issue/handshake decode. Counting the in-flight read against free space
  // means a returning read always has a slot, so the FIFO never overflows.
  always_comb begin
    issue_ok_s = (({1'b0, occ_q} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(DEPTH));
    im_req     = !RST && fetch_en && !redirect && issue_ok_s;
    im_addr    = fetch_pc_q[ADDR_W-1:0];
    empty_s    = (occ_q == '0);
    // A redirect hides the head so nothing is consumed in the flush cycle.
    inst_valid = !empty_s && !redirect;
    pop_s      = inst_valid && inst_ready;
    // Read data returning during a redirect belongs to the killed path.
    push_s     = inflight_q && !redirect;
    if (empty_s) begin
      inst_out = '0;
      inst_pc  = '0;
    end else begin
      inst_out = data_mem_q[rd_ptr_q];
      inst_pc  = pc_mem_q[rd_ptr_q];
    end
    occupancy = occ_q;
  end

  // Next-state logic for PC, in-flight tracking and FIFO pointers/count.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = im_req;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    if (redirect) begin
      fetch_pc_d = redirect_target;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
    end else begin
      if (im_req) begin
        fetch_pc_d = fetch_pc_q + DATA_W'(1);
        req_pc_d   = fetch_pc_q;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   occ_d = occ_q + CW'(1);
        2'b01:   occ_d = occ_q - CW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  // FIFO storage; contents need no reset because the count gates the outputs.
  always_ff @(posedge CLK) begin
    if (!RST && push_s) begin
      data_mem_q[wr_ptr_q] <= im_rdata;
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
    end else begin
      data_mem_q[wr_ptr_q] <= data_mem_q[wr_ptr_q];
      pc_mem_q[wr_ptr_q]   <= pc_mem_q[wr_ptr_q];
    end
  end

  fetch_unit_chk #(
    .CW    (CW),
    .DEPTH (DEPTH)
  ) u_chk (
    .CLK    (CLK),
    .RST    (RST),
    .push_i (push_s),
    .occ_i  (occ_q)
  );

endmodule

// fetch_unit_chk -- protocol checker for fetch_unit.
//
// Ports:
//   CLK, RST  clock and synchronous reset of the checked block
//   push_i    FIFO push this cycle
//   occ_i     FIFO occupancy this cycle
module fetch_unit_chk #(
  parameter int unsigned CW    = 3,
  parameter int unsigned DEPTH = 4
) (
  input logic          CLK,
  input logic          RST,
  input logic          push_i,
  input logic [CW-1:0] occ_i
);

  // A push into a full FIFO would mean the issue rule was violated.
  a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
    push_i |-> (occ_i != CW'(DEPTH)));

endmodule
